// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared defaults and pointer-width helper for the FIFO read stream adapter
package fifo_stream_pkg;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PKT_LEN = 16;
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/stream_buf_fifo.sv
// stream_buf_fifo: small circular buffer absorbing the FIFO read latency
module stream_buf_fifo
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4,
    localparam int PW = clog2_min1(DEPTH),
    localparam int OW = clog2_min1(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic [OW-1:0]    occ
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    // pointers wrap at DEPTH; occupancy tracks writes minus reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (wr_en) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (rd_en) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            occ <= occ + OW'(wr_en) - OW'(rd_en);
        end
    end
    // storage needs no reset; reads are qualified by occupancy upstream
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wdata;
    end
    assign rdata = mem[rptr];
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: drains an async FIFO pop port into a framed valid/ready stream
module fifo_rd_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BUF_DEPTH = 4,
    parameter int PKT_LEN   = DEF_PKT_LEN,
    parameter int CNT_W     = 16
) (
    input  logic             rd_clk,
    input  logic             res_n,
    input  logic             fifo_empty,
    input  logic             fifo_underflow,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err_underflow
);
    localparam int OW = clog2_min1(BUF_DEPTH + 1);
    localparam int BW = clog2_min1(PKT_LEN);
    logic [OW-1:0]    occ;
    logic [OW:0]      pending;
    logic [BW-1:0]    beat_idx;
    logic [WIDTH-1:0] buf_data;
    logic             inflight;
    logic             run;
    logic             hs;
    // issue only from registered state so out_ready never reaches fifo_rd_en
    assign pending    = {1'b0, occ} + {{OW{1'b0}}, inflight};
    assign fifo_rd_en = run && !fifo_empty && (pending < (OW + 1)'(BUF_DEPTH));
    assign out_valid  = (occ != '0);
    assign hs         = out_valid && out_ready;
    assign out_data   = out_valid ? buf_data : '0;
    assign out_last   = out_valid && (beat_idx == BW'(PKT_LEN - 1));
    // run keeps pops off until the first edge after reset release
    always_ff @(posedge rd_clk or negedge res_n) begin
        if (!res_n) begin
            run           <= 1'b0;
            inflight      <= 1'b0;
            beat_idx      <= '0;
            word_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            run      <= 1'b1;
            inflight <= fifo_rd_en;
            if (hs) begin
                beat_idx <= (beat_idx == BW'(PKT_LEN - 1)) ? '0 : beat_idx + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end
            if (fifo_underflow) err_underflow <= 1'b1;
        end
    end
    stream_buf_fifo #(.WIDTH(WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
        .clk   (rd_clk),
        .rst_n (res_n),
        .wr_en (inflight),
        .wdata (fifo_rdata),
        .rd_en (hs),
        .rdata (buf_data),
        .occ   (occ)
    );
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed tests of the FIFO read stream adapter against a FIFO model
module tb_fifo_rd_stream_adapter;
    localparam int WIDTH     = 8;
    localparam int BUF_DEPTH = 4;
    localparam int PKT_LEN   = 16;
    localparam int CNT_W     = 8;

    logic             rd_clk;
    logic             res_n;
    logic             fifo_empty;
    logic             fifo_underflow;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_rd_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [CNT_W-1:0] word_cnt;
    logic             err_underflow;
    logic             force_empty;

    logic [7:0] src [4096];
    int         head;
    int         tail;
    logic [7:0] cap_data [4096];
    logic       cap_last [4096];
    int         cap_cyc  [4096];
    int         cap_n;
    int         cyc;
    int         total;
    int         bad;

    fifo_rd_stream_adapter #(
        .WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)
    ) dut (
        .rd_clk         (rd_clk),
        .res_n          (res_n),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_rdata     (fifo_rdata),
        .fifo_rd_en     (fifo_rd_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .word_cnt       (word_cnt),
        .err_underflow  (err_underflow)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // FIFO model: one-cycle read latency, empty when drained or forced
    assign fifo_empty = force_empty || (head == tail);
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rdata <= src[head];
            head <= head + 1;
        end
    end

    // downstream monitor records every handshake
    always @(negedge rd_clk) begin
        cyc <= cyc + 1;
        if (res_n && out_valid && out_ready) begin
            cap_data[cap_n] <= out_data;
            cap_last[cap_n] <= out_last;
            cap_cyc[cap_n]  <= cyc;
            cap_n <= cap_n + 1;
        end
    end

    // local buffer must never exceed its depth
    always @(negedge rd_clk) begin
        if (res_n) begin
            total++;
            if (int'(dut.u_buf.occ) > BUF_DEPTH) begin
                bad++;
                $display("FAIL occ_bound occ=%0d max=%0d", dut.u_buf.occ, BUF_DEPTH);
            end
        end
    end

    task automatic tick;
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            src[tail] = 8'(base + i * step);
            tail = tail + 1;
        end
    endtask

    task automatic do_reset;
        res_n = 1'b0;
        repeat (2) @(posedge rd_clk);
        #1 res_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        res_n = 1'b0;
        force_empty = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || fifo_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs valid=%b data=%h last=%b rd_en=%b want 0 00 0 0", out_valid, out_data, out_last, fifo_rd_en);
        end
        total++;
        if (word_cnt !== 8'd0 || err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_counters word_cnt=%0d err=%b want 0 0", word_cnt, err_underflow);
        end
        force_empty = 1'b1;
        #1 res_n = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid_stream;
        int s;
        int k;
        int seen;
        force_empty = 1'b1;
        out_ready = 1'b1;
        push(2, 8'h90, 1);
        s = cap_n;
        force_empty = 1'b0;
        for (k = 0; k < 40 && cap_n < s + 2; k++) tick;
        total++;
        if (cap_n != s + 2) begin
            bad++;
            $display("FAIL mid_prefill got=%0d want=2", cap_n - s);
        end
        out_ready = 1'b0;
        push(8, 8'hA0, 1);
        for (k = 0; k < 20; k++) begin
            @(negedge rd_clk);
            if (dut.u_buf.occ == 3 && dut.inflight) break;
        end
        total++;
        if (!(dut.u_buf.occ == 3 && dut.inflight)) begin
            bad++;
            $display("FAIL mid_fill occ=%0d inflight=%b want 3 1", dut.u_buf.occ, dut.inflight);
        end
        res_n = 1'b0;
        force_empty = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_async valid=%b rd_en=%b want 0 0", out_valid, fifo_rd_en);
        end
        tick;
        total++;
        if (out_valid !== 1'b0 || word_cnt !== 8'd0 || dut.beat_idx !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset valid=%b word_cnt=%0d beat=%0d want 0 0 0", out_valid, word_cnt, dut.beat_idx);
        end
        tick;
        res_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (k = 0; k < 10; k++) begin
            @(negedge rd_clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_stale valid_cycles=%0d want=0", seen);
        end
        tick;
        s = cap_n;
        force_empty = 1'b0;
        for (k = 0; k < 40 && cap_n < s + 4; k++) tick;
        total++;
        if (cap_n != s + 4) begin
            bad++;
            $display("FAIL mid_resume got=%0d want=4", cap_n - s);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cap_data[s + i] !== 8'(8'hA4 + i)) begin
                bad++;
                $display("FAIL mid_data[%0d] got=%h want=%h", i, cap_data[s + i], 8'(8'hA4 + i));
            end
        end
        total++;
        if (word_cnt !== 8'd4) begin
            bad++;
            $display("FAIL mid_word_cnt got=%0d want=4", word_cnt);
        end
    endtask

    task automatic test_stream;
        int s;
        int k;
        force_empty = 1'b1;
        do_reset;
        out_ready = 1'b1;
        push(32, 0, 1);
        s = cap_n;
        force_empty = 1'b0;
        #1;
        total++;
        if (fifo_rd_en !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_issue rd_en=%b valid=%b want 1 0", fifo_rd_en, out_valid);
        end
        tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_cycle1 valid=%b want 0", out_valid);
        end
        tick;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL lat_cycle2 valid=%b data=%h want 1 00", out_valid, out_data);
        end
        for (k = 0; k < 100 && cap_n < s + 32; k++) tick;
        total++;
        if (cap_n != s + 32) begin
            bad++;
            $display("FAIL stream_count got=%0d want=32", cap_n - s);
        end
        for (int i = 0; i < 32; i++) begin
            total++;
            if (cap_data[s + i] !== 8'(i) || cap_last[s + i] !== (i == 15 || i == 31) || cap_cyc[s + i] != cap_cyc[s] + i) begin
                bad++;
                $display("FAIL stream[%0d] data=%h last=%b cyc=%0d want %h %b %0d", i, cap_data[s + i], cap_last[s + i],
                         cap_cyc[s + i] - cap_cyc[s], 8'(i), (i == 15 || i == 31), i);
            end
        end
        total++;
        if (word_cnt !== 8'd32) begin
            bad++;
            $display("FAIL stream_word_cnt got=%0d want=32", word_cnt);
        end
    endtask

    task automatic test_back_pressure;
        int s;
        int k;
        int issues;
        int unstable;
        logic held_set;
        logic [7:0] held;
        force_empty = 1'b1;
        do_reset;
        out_ready = 1'b0;
        push(8, 8'h40, 1);
        s = cap_n;
        force_empty = 1'b0;
        issues = 0;
        unstable = 0;
        held_set = 1'b0;
        held = 8'h00;
        for (k = 0; k < 20; k++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) issues++;
            if (out_valid) begin
                if (!held_set) begin
                    held = out_data;
                    held_set = 1'b1;
                end else if (out_data !== held) unstable++;
            end
        end
        total++;
        if (issues != 4) begin
            bad++;
            $display("FAIL bp_issues got=%0d want=4", issues);
        end
        total++;
        if (!held_set || held !== 8'h40 || unstable != 0) begin
            bad++;
            $display("FAIL bp_hold data=%h changes=%0d want 40 0", held, unstable);
        end
        tick;
        out_ready = 1'b1;
        for (k = 0; k < 50 && cap_n < s + 8; k++) tick;
        repeat (6) tick;
        total++;
        if (cap_n != s + 8) begin
            bad++;
            $display("FAIL bp_count got=%0d want=8", cap_n - s);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap_data[s + i] !== 8'(8'h40 + i)) begin
                bad++;
                $display("FAIL bp_data[%0d] got=%h want=%h", i, cap_data[s + i], 8'(8'h40 + i));
            end
        end
    endtask

    task automatic test_empty;
        int issues;
        int errs;
        force_empty = 1'b1;
        issues = 0;
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) issues++;
            if (err_underflow) errs++;
        end
        total++;
        if (issues != 0 || errs != 0) begin
            bad++;
            $display("FAIL empty_idle rd_en_cycles=%0d err_cycles=%0d want 0 0", issues, errs);
        end
        tick;
    endtask

    task automatic test_underflow;
        int s;
        int k;
        force_empty = 1'b1;
        do_reset;
        out_ready = 1'b1;
        push(8, 8'h60, 1);
        s = cap_n;
        force_empty = 1'b0;
        repeat (3) tick;
        fifo_underflow = 1'b1;
        tick;
        fifo_underflow = 1'b0;
        total++;
        if (err_underflow !== 1'b1) begin
            bad++;
            $display("FAIL uf_set got=%b want=1", err_underflow);
        end
        for (k = 0; k < 50 && cap_n < s + 8; k++) tick;
        repeat (4) tick;
        total++;
        if (err_underflow !== 1'b1 || cap_n != s + 8 || word_cnt !== 8'd8) begin
            bad++;
            $display("FAIL uf_sticky err=%b count=%0d word_cnt=%0d want 1 8 8", err_underflow, cap_n - s, word_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cap_data[s + i] !== 8'(8'h60 + i)) begin
                bad++;
                $display("FAIL uf_data[%0d] got=%h want=%h", i, cap_data[s + i], 8'(8'h60 + i));
            end
        end
        force_empty = 1'b1;
        do_reset;
        total++;
        if (err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL uf_clear got=%b want=0", err_underflow);
        end
    endtask

    task automatic test_random;
        int s;
        int k;
        int errs;
        force_empty = 1'b1;
        do_reset;
        push(2000, 3, 7);
        s = cap_n;
        for (k = 0; k < 30000 && cap_n < s + 2000; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            force_empty = ($urandom_range(0, 3) == 0);
            tick;
        end
        out_ready = 1'b0;
        repeat (4) tick;
        total++;
        if (cap_n != s + 2000) begin
            bad++;
            $display("FAIL rnd_count got=%0d want=2000", cap_n - s);
        end
        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            total++;
            if (cap_data[s + i] !== 8'(3 + i * 7) || cap_last[s + i] !== ((i % 16) == 15)) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rnd[%0d] data=%h last=%b want %h %b", i, cap_data[s + i], cap_last[s + i],
                             8'(3 + i * 7), ((i % 16) == 15));
            end
        end
        total++;
        if (word_cnt !== 8'd208) begin
            bad++;
            $display("FAIL rnd_word_cnt got=%0d want=208", word_cnt);
        end
    endtask

    initial begin
        res_n = 1'b0;
        force_empty = 1'b1;
        fifo_underflow = 1'b0;
        out_ready = 1'b0;
        test_reset;
        test_reset_mid_stream;
        test_stream;
        test_back_pressure;
        test_empty;
        test_underflow;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
